// File: rtl/ring_detector.sv
// ring_detector: synchronises and debounces the raw ring indication from the
// line interface. It qualifies a genuine ring burst and holds is_ringing high
// across the silent gaps of the ring cadence, so downstream logic sees one
// clean level for the whole call alert.
//
// Optional build macro: RING_BURST_COUNT_EN adds the ring_bursts output, an
// 8-bit saturating count of entries into RINGING within the current alert.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no ring activity; timer held at 0
// QUALIFY | debounced level high; timing the burst against ON_MIN_CYCLES
// RINGING | qualified ring burst in progress; is_ringing high
// GAP     | debounced level low inside a cadence; timing against HOLD_CYCLES
module ring_detector #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ON_MIN_CYCLES   = 64,
    parameter int HOLD_CYCLES     = 256,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ring_raw,
    output logic       is_ringing,
    output logic       ring_start
`ifdef RING_BURST_COUNT_EN
    ,
    output logic [7:0] ring_bursts
`endif
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_MIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        RINGING = 2'd2,
        GAP     = 2'd3
    } state_t;

    logic             ring_m;
    logic             ring_s;
    logic             deb;
    logic [CNT_W-1:0] deb_cnt;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] tmr_q;
    logic [CNT_W-1:0] tmr_d;
    logic             ringing_d;
    logic             start_d;

    // Two-flop synchroniser for the asynchronous ring indication.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ring_m <= 1'b0;
            ring_s <= 1'b0;
        end else begin
            ring_m <= ring_raw;
            ring_s <= ring_m;
        end
    end

    // Debounce: deb follows ring_s only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (ring_s == deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb     <= ~deb;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // State, shared timer and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            is_ringing <= 1'b0;
            ring_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            is_ringing <= ringing_d;
            ring_start <= start_d;
        end
    end

    // Next-state logic. A drop during QUALIFY beats qualification, and a
    // resume during GAP beats hold expiry, because the deb test comes first.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        ringing_d = is_ringing;
        start_d   = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_d     = '0;
                ringing_d = 1'b0;
                if (deb) begin
                    state_d = QUALIFY;
                    tmr_d   = TMR_ONE;
                end
            end
            QUALIFY: begin
                ringing_d = 1'b0;
                if (!deb) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == ON_LAST) begin
                    state_d   = RINGING;
                    tmr_d     = '0;
                    ringing_d = 1'b1;
                    start_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RINGING: begin
                ringing_d = 1'b1;
                tmr_d     = '0;
                if (!deb) begin
                    state_d = GAP;
                    tmr_d   = TMR_ONE;
                end
            end
            GAP: begin
                ringing_d = 1'b1;
                if (deb) begin
                    state_d = RINGING;
                    tmr_d   = '0;
                end else if (tmr_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    tmr_d     = '0;
                    ringing_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                tmr_d     = '0;
                ringing_d = 1'b0;
            end
        endcase
    end

`ifdef RING_BURST_COUNT_EN
    logic burst_clr;
    logic burst_inc;

    assign burst_clr = (state_q == IDLE) && deb;
    assign burst_inc = deb && (((state_q == QUALIFY) && (tmr_q == ON_LAST)) ||
                               (state_q == GAP));

    // Saturating count of RINGING entries, restarted when a new alert begins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ring_bursts <= 8'd0;
        end else if (burst_clr) begin
            ring_bursts <= 8'd0;
        end else if (burst_inc && (ring_bursts != 8'hFF)) begin
            ring_bursts <= ring_bursts + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ring_detector.sv
// Testbench for ring_detector with DEBOUNCE_CYCLES=4, ON_MIN_CYCLES=8,
// HOLD_CYCLES=20. A cadence-level model derives the expected outputs from
// run lengths of the sampled input; directed latencies pin the model.
module tb_ring_detector;

    localparam int DEB  = 4;
    localparam int ONM  = 8;
    localparam int HOLD = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ring_raw = 1'b1;
    logic is_ringing;
    logic ring_start;
`ifdef RING_BURST_COUNT_EN
    logic [7:0] ring_bursts;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_falls  = 0;
    logic prev_ring = 1'b0;
    logic started   = 1'b0;

    ring_detector #(
        .DEBOUNCE_CYCLES(DEB),
        .ON_MIN_CYCLES  (ONM),
        .HOLD_CYCLES    (HOLD),
        .CNT_W          (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ring_raw   (ring_raw),
        .is_ringing (is_ringing),
        .ring_start (ring_start)
`ifdef RING_BURST_COUNT_EN
        ,
        .ring_bursts(ring_bursts)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: raw samples history; deb flips once the last DEB synchronised
    // samples all disagree with it; ringing follows high/low run lengths.
    logic [DEB+1:0] m_hist;
    logic m_deb, m_ringing, m_start, m_deb_old, m_all_diff;
    int   m_hi_run, m_lo_run, m_prev_lo, m_bursts;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_hist    = '0;
            m_deb     = 1'b0;
            m_ringing = 1'b0;
            m_start   = 1'b0;
            m_hi_run  = 0;
            m_lo_run  = 0;
            m_bursts  = 0;
        end else begin
            m_hist     = {m_hist[DEB:0], ring_raw};
            m_deb_old  = m_deb;
            m_all_diff = 1'b1;
            for (int i = 2; i <= DEB + 1; i++)
                if (m_hist[i] == m_deb) m_all_diff = 1'b0;
            if (m_all_diff) m_deb = ~m_deb;
            m_prev_lo = m_lo_run;
            if (m_deb_old) begin
                m_hi_run++;
                m_lo_run = 0;
            end else begin
                m_lo_run++;
                m_hi_run = 0;
            end
            m_start = 1'b0;
            if (!m_ringing) begin
                if (m_hi_run == 1) m_bursts = 0;
                if (m_hi_run == ONM) begin
                    m_ringing = 1'b1;
                    m_start   = 1'b1;
                    if (m_bursts < 255) m_bursts++;
                end
            end else begin
                if (m_deb_old && m_prev_lo > 0 && m_bursts < 255) m_bursts++;
                if (m_lo_run == HOLD) m_ringing = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, plus event tallies.
    always @(negedge clock) begin
        if (started) begin
            check("is_ringing", is_ringing, m_ringing);
            check("ring_start", ring_start, m_start);
`ifdef RING_BURST_COUNT_EN
            check("ring_bursts", ring_bursts, m_bursts);
`endif
            if (ring_start) n_starts++;
            if (prev_ring && !is_ringing) n_falls++;
            prev_ring = is_ringing;
        end
    end

    task automatic drive(input logic v, input int n);
        ring_raw = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_level(input logic lvl, input int max, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (is_ringing !== lvl && n < max);
        if (is_ringing !== lvl) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_level: is_ringing=%0b, expected %0b within %0d cycles", is_ringing, lvl, max);
        end
    endtask

    int n, s0, f0;

    initial begin
        // Reset held with ring_raw high.
        repeat (2) @(negedge clock);
        started = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_is_ringing", is_ringing, 0);
        check("reset_ring_start", ring_start, 0);
        s0 = n_starts;
        reset = 1'b1;
        wait_level(1'b1, 100, n);
        check("release_latency", n, 14);
        drive(1'b1, 5);
        check("release_starts", n_starts - s0, 1);
        ring_raw = 1'b0;
        wait_level(1'b0, 100, n);
        check("first_fall_latency", n, 26);
        drive(1'b0, 10);

        // Glitch rejection.
        s0 = n_starts;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 3);
            drive(1'b0, 1);
        end
        drive(1'b0, 12);
        check("glitch_is_ringing", is_ringing, 0);
        check("glitch_starts", n_starts - s0, 0);

        // Burst one cycle short of qualifying: drop wins.
        drive(1'b1, 7);
        drive(1'b0, 20);
        check("short_is_ringing", is_ringing, 0);
        check("short_starts", n_starts - s0, 0);

        // Burst exactly long enough to qualify.
        drive(1'b1, 8);
        ring_raw = 1'b0;
        wait_level(1'b1, 100, n);
        check("min_burst_rise", n, 6);
        wait_level(1'b0, 100, n);
        check("min_burst_fall", n, 20);
        drive(1'b0, 10);

        // Cadence hold: three bursts with 12-cycle gaps.
        s0 = n_starts;
        f0 = n_falls;
        ring_raw = 1'b1;
        wait_level(1'b1, 100, n);
        check("cadence_rise", n, 14);
        drive(1'b1, 16);
        drive(1'b0, 12);
        drive(1'b1, 30);
        drive(1'b0, 12);
        drive(1'b1, 30);
        check("cadence_held", is_ringing, 1);
        check("cadence_no_fall", n_falls - f0, 0);
        ring_raw = 1'b0;
        wait_level(1'b0, 100, n);
        check("cadence_fall", n, 26);
        drive(1'b0, 3);
        check("cadence_starts", n_starts - s0, 1);
        check("cadence_falls", n_falls - f0, 1);
`ifdef RING_BURST_COUNT_EN
        check("cadence_bursts", ring_bursts, 3);
`endif
        drive(1'b0, 5);

        // Gap boundary: 19 cycles survives, 20 cycles ends the alert.
        ring_raw = 1'b1;
        wait_level(1'b1, 100, n);
        check("gap_rise", n, 14);
        drive(1'b1, 16);
        s0 = n_starts;
        f0 = n_falls;
        drive(1'b0, 19);
        drive(1'b1, 30);
        check("gap19_held", is_ringing, 1);
        check("gap19_no_fall", n_falls - f0, 0);
        drive(1'b0, 20);
        ring_raw = 1'b1;
        wait_level(1'b0, 100, n);
        check("gap20_fall", n, 6);
        wait_level(1'b1, 100, n);
        check("gap20_requalify", n, 8);
        drive(1'b1, 3);
        check("gap20_starts", n_starts - s0, 1);
        check("gap20_falls", n_falls - f0, 1);
`ifdef RING_BURST_COUNT_EN
        check("gap20_bursts", ring_bursts, 1);
`endif

        // Asynchronous reset while in GAP.
        drive(1'b1, 10);
        drive(1'b0, 10);
        check("pre_reset_ringing", is_ringing, 1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_ringing", is_ringing, 0);
        check("async_reset_start", ring_start, 0);
        ring_raw = 1'b1;
        @(negedge clock);
        @(negedge clock);
        s0 = n_starts;
        reset = 1'b1;
        wait_level(1'b1, 100, n);
        check("post_reset_latency", n, 14);
        drive(1'b1, 4);
        check("post_reset_starts", n_starts - s0, 1);
        ring_raw = 1'b0;
        wait_level(1'b0, 100, n);
        check("post_reset_fall", n, 26);
        drive(1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
